// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, IR-stage valid/ready port,
// and the branch redirect / fault signals.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  logic [15:0]       ir_d;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              fetch_fault;

  modport master (
    output mem_req, mem_addr, ir_d, ir_pc, ir_valid, fetch_fault,
    input  mem_rdata, mem_ack, ir_ready, branch_en, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, ir_d, ir_pc, ir_valid, fetch_fault,
    output mem_rdata, mem_ack, ir_ready, branch_en, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads memory over req/ack, hands words to the IR stage.
// Optional FETCH_TIMEOUT_EN adds a memory-ack timeout that halts with a sticky fetch_fault.
module instr_fetch #(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master io_bus
);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [2:0] {StIdle, StFetch, StHold, StDrop, StHalt} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrop} state_e;
`endif

  state_e            r_state, w_state;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic              r_mem_req, w_mem_req;
  logic [15:0]       r_ir_d, w_ir_d;
  logic [ADDR_W-1:0] r_ir_pc, w_ir_pc;
  logic              r_ir_valid, w_ir_valid;
  logic [ADDR_W-1:0] w_pc_inc;

`ifdef FETCH_TIMEOUT_EN
  logic [CntW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic            r_fault, w_fault;
  logic            w_expire, w_clr;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_expire  = r_mem_req && !io_bus.mem_ack && (w_cnt_inc == CntW'(TIMEOUT_CYC));
`endif

  assign w_pc_inc = r_pc + 1'b1;

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_mem_addr = r_mem_addr;
    w_mem_req  = r_mem_req;
    w_ir_d     = r_ir_d;
    w_ir_pc    = r_ir_pc;
    w_ir_valid = r_ir_valid;
`ifdef FETCH_TIMEOUT_EN
    w_fault    = r_fault;
    w_cnt      = r_cnt;
    w_clr      = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        w_pc       = io_bus.branch_en ? io_bus.branch_target : r_pc;
        w_mem_addr = w_pc;
        w_mem_req  = 1'b1;
        w_state    = StFetch;
      end
      StFetch: begin
        if (io_bus.branch_en) begin
          // Data of a coincident ack is dropped; without ack the request must run out in DROP.
          w_pc = io_bus.branch_target;
          if (io_bus.mem_ack) w_mem_addr = io_bus.branch_target;
          else                w_state    = StDrop;
        end else if (io_bus.mem_ack) begin
          w_ir_d     = io_bus.mem_rdata;
          w_ir_pc    = r_mem_addr;
          w_ir_valid = 1'b1;
          w_mem_req  = 1'b0;
          w_pc       = w_pc_inc;
          w_state    = StHold;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_expire) begin
          w_mem_req  = 1'b0;
          w_ir_valid = 1'b0;
          w_fault    = 1'b1;
          w_state    = StHalt;
        end
`endif
      end
      StHold: begin
        if (io_bus.branch_en) begin
          w_ir_valid = 1'b0;
          w_pc       = io_bus.branch_target;
          w_mem_addr = io_bus.branch_target;
          w_mem_req  = 1'b1;
          w_state    = StFetch;
        end else if (io_bus.ir_ready) begin
          w_ir_valid = 1'b0;
          w_mem_addr = r_pc;
          w_mem_req  = 1'b1;
          w_state    = StFetch;
        end
      end
      StDrop: begin
        if (io_bus.branch_en) w_pc = io_bus.branch_target;
        if (io_bus.mem_ack) begin
          w_mem_addr = w_pc;
          w_state    = StFetch;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (!io_bus.branch_en && w_expire) begin
          w_mem_req  = 1'b0;
          w_ir_valid = 1'b0;
          w_fault    = 1'b1;
          w_state    = StHalt;
        end
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      StHalt: ;
`endif
      default: w_state = StIdle;
    endcase
`ifdef FETCH_TIMEOUT_EN
    // A fresh request (or the switch into DROP) restarts the timeout window.
    w_clr = w_mem_req && (!r_mem_req || io_bus.mem_ack ||
                          (r_state == StFetch && w_state == StDrop));
    if (w_clr)                               w_cnt = '0;
    else if (r_mem_req && !io_bus.mem_ack)   w_cnt = w_cnt_inc;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_ir_d     <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_mem_addr <= w_mem_addr;
      r_mem_req  <= w_mem_req;
      r_ir_d     <= w_ir_d;
      r_ir_pc    <= w_ir_pc;
      r_ir_valid <= w_ir_valid;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_cnt   <= w_cnt;
      r_fault <= w_fault;
    end
  end

  assign io_bus.fetch_fault = r_fault;
`else
  assign io_bus.fetch_fault = 1'b0;
`endif

  assign io_bus.mem_req  = r_mem_req;
  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.ir_d     = r_ir_d;
  assign io_bus.ir_pc    = r_ir_pc;
  assign io_bus.ir_valid = r_ir_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model answers requests, the reference model
// predicts the accepted instruction stream, and a monitor pops and compares each transfer.
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int unsigned AW  = 16;
  localparam logic [15:0] RPC = 16'h0010;
  localparam int unsigned TO  = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(AW)) bus ();

  instr_fetch #(.ADDR_W(AW), .RESET_PC(RPC), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  int          checks    = 0;
  int          failures  = 0;
  int          transfers = 0;
  exp_t        exp_q[$];
  logic [15:0] addr_log[$];
  int          fixed_lat = 0;
  bit          mem_hang  = 1'b0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C69;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference model: after a redirect the next accepted word is the target.
  task automatic model_restart(input logic [15:0] pc);
    exp_q.delete();
    exp_q.push_back('{pc: pc, d: memf(pc)});
  endtask

  // Memory: each new request answered after a fixed or random number of wait cycles.
  bit          req_active = 1'b0;
  logic [15:0] req_addr;
  int          req_wait;
  always begin
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'($urandom);
    if (!rst) begin
      req_active = 1'b0;
    end else if (bus.mem_req) begin
      if (!req_active) begin
        req_active = 1'b1;
        req_addr   = bus.mem_addr;
        req_wait   = mem_hang ? 1000000 : (fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3)));
        addr_log.push_back(bus.mem_addr);
      end else begin
        chk("mem_addr_stable", bus.mem_addr, req_addr);
      end
      if (req_wait == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = memf(req_addr);
        req_active    = 1'b0;
      end else begin
        req_wait--;
      end
    end else if (req_active) begin
      if (!mem_hang) chk("mem_req_withdrawn", 1, 0);
      req_active = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks HOLD stability.
  bit          prev_hold = 1'b0;
  logic [15:0] prev_pc, prev_d;
  exp_t        e;
  logic [15:0] nxt;
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.ir_valid, 1);
        chk("hold_pc", bus.ir_pc, prev_pc);
        chk("hold_d", bus.ir_d, prev_d);
      end
      if (bus.ir_valid) chk("req_low_in_hold", bus.mem_req, 0);
      prev_hold = 1'b0;
      if (bus.ir_valid && !bus.branch_en) begin
        if (bus.ir_ready) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("ir_pc", bus.ir_pc, e.pc);
            chk("ir_d", bus.ir_d, e.d);
            transfers++;
            nxt = e.pc + 16'd1;
            exp_q.push_back('{pc: nxt, d: memf(nxt)});
          end
        end else begin
          prev_hold = 1'b1;
          prev_pc   = bus.ir_pc;
          prev_d    = bus.ir_d;
        end
      end
    end
  end

  task automatic do_branch(input logic [15:0] t);
    bus.branch_en     = 1'b1;
    bus.branch_target = t;
    model_restart(t);
    @(negedge clk);
    bus.branch_en = 1'b0;
  endtask

  task automatic wait_log(input int n, input string nm);
    int k;
    k = 0;
    while (addr_log.size() < n && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (addr_log.size() < n) chk(nm, addr_log.size(), n);
  endtask

  task automatic wait_cond_req(input string nm);
    int k;
    k = 0;
    while (!bus.mem_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.mem_req) chk(nm, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, n, k;
    logic [15:0] exp_next;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.ir_ready = 1'b1;
    bus.branch_en = 1'b0; bus.branch_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, RPC);
    chk("rst_ir_valid", bus.ir_valid, 0);
    chk("rst_ir_pc", bus.ir_pc, 0);
    chk("rst_ir_d", bus.ir_d, 0);
    chk("rst_fault", bus.fetch_fault, 0);

    // Zero-wait memory, ir_ready high: sequential addresses, one word every 2 cycles.
    model_restart(RPC);
    addr_log.delete();
    rst = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ir_valid) nv++;
    end
    chk("valid_duty", nv, 5);
    wait_log(3, "seq_reqs_seen");
    if (addr_log.size() >= 3) begin
      chk("seq_addr0", addr_log[0], 16'h0010);
      chk("seq_addr1", addr_log[1], 16'h0011);
      chk("seq_addr2", addr_log[2], 16'h0012);
    end

    // IR stall: instruction held, no request, then fetch resumes at pc+1.
    bus.ir_ready = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.ir_valid && k < 40);
    chk("stall_valid_seen", bus.ir_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_low", bus.mem_req, 0);
    end
    exp_next = exp_q[0].pc + 16'd1;
    n = addr_log.size();
    bus.ir_ready = 1'b1;
    wait_log(n + 1, "resume_req_seen");
    if (addr_log.size() > n) chk("resume_addr", addr_log[n], exp_next);

    // Redirect while FETCH waits on a slow ack: old request runs out, next at target.
    fixed_lat = 3;
    n = addr_log.size();
    wait_log(n + 1, "slow_req_seen");
    @(negedge clk);
    #1;
    n = addr_log.size();
    do_branch(16'h0200);
    wait_log(n + 1, "drop_req_seen");
    if (addr_log.size() > n) chk("drop_next_addr", addr_log[n], 16'h0200);

    // Redirect in HOLD with ir_ready high: no transfer, next request at target.
    fixed_lat = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.ir_valid && k < 40);
    #1;
    n = addr_log.size();
    do_branch(16'h1234);
    chk("hold_branch_kill", bus.ir_valid, 0);
    wait_log(n + 1, "hold_branch_req_seen");
    if (addr_log.size() > n) chk("hold_branch_addr", addr_log[n], 16'h1234);

    // Redirect coincident with ack: request to target in the very next cycle.
    @(negedge clk);
    wait_cond_req("ack_branch_req_wait");
    #1;
    n = addr_log.size();
    do_branch(16'h0300);
    chk("ack_branch_req", bus.mem_req, 1);
    chk("ack_branch_addr", bus.mem_addr, 16'h0300);
    chk("ack_branch_valid", bus.ir_valid, 0);

    // PC wrap.
    @(negedge clk);
    #1;
    n = addr_log.size();
    do_branch(16'hFFFF);
    wait_log(n + 2, "wrap_reqs_seen");
    if (addr_log.size() > n + 1) begin
      chk("wrap_addr0", addr_log[n], 16'hFFFF);
      chk("wrap_addr1", addr_log[n + 1], 16'h0000);
    end

    // Random traffic with a reset in the middle.
    fixed_lat = -1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        bus.ir_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 99) < 8) begin
          k = $urandom_range(0, 3);
          bus.branch_en     = 1'b1;
          bus.branch_target = (k == 0) ? 16'hFFFF : (k == 1) ? 16'hFFFE : 16'($urandom);
          model_restart(bus.branch_target);
        end else begin
          bus.branch_en = 1'b0;
        end
      end
      if (pass == 0) begin
        @(negedge clk);
        bus.branch_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req", bus.mem_req, 0);
        chk("midrst_valid", bus.ir_valid, 0);
        chk("midrst_addr", bus.mem_addr, RPC);
        model_restart(RPC);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    bus.branch_en = 1'b0;
    bus.ir_ready  = 1'b1;
    chk("random_transfers", transfers > 50, 1);

    // Memory that never acks.
    fixed_lat = 0;
    mem_hang  = 1'b1;
    repeat (20) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    chk("to_req_dropped", bus.mem_req, 0);
    chk("to_fault", bus.fetch_fault, 1);
    do_branch(16'h0400);
    repeat (3) @(negedge clk);
    chk("to_branch_ignored_req", bus.mem_req, 0);
    chk("to_fault_sticky", bus.fetch_fault, 1);
`else
    chk("hang_req_held", bus.mem_req, 1);
    chk("hang_no_fault", bus.fetch_fault, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("hang_rst_req", bus.mem_req, 0);
    chk("hang_rst_fault", bus.fetch_fault, 0);
    mem_hang = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
